instr_encoder: RTL

- Sequential instruction encoder; the inverse of the opcode/funct decode in the control unit.
- Accepts instruction descriptors over a valid/ready handshake and packs them into 32-bit MIPS words.
- Writes each word into instruction memory at sequential word addresses through a registered, back-pressurable write port.
- Sits between the test/boot loader and the instruction memory, so programs are built from the same opcode set that the control unit decodes.

---
 rtl/instr_encoder_pkg.sv | 41 ++++
 rtl/instr_encoder_pack.sv | 25 ++
 rtl/instr_encoder.sv | 135 +++++++++++++
 3 files changed

// File: rtl/instr_encoder_pkg.sv
// Shared opcode/funct constants, descriptor kinds and encoder state encoding.
// The opcode and funct values match the control unit decode.
package instr_encoder_pkg;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_JAL   = 6'h03;

    localparam logic [5:0] FN_ADDU  = 6'h21;
    localparam logic [5:0] FN_SUBU  = 6'h23;

    typedef enum logic [2:0] {
        K_ADDU    = 3'd0,
        K_SUBU    = 3'd1,
        K_ORI     = 3'd2,
        K_LW      = 3'd3,
        K_SW      = 3'd4,
        K_BEQ     = 3'd5,
        K_JAL     = 3'd6,
        K_ILLEGAL = 3'd7
    } kind_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_DONE = 2'd2,
        ST_ERR  = 2'd3
    } state_e;

    typedef struct packed {
        kind_e       kind;
        logic [4:0]  rs;
        logic [4:0]  rt;
        logic [4:0]  rd;
        logic [25:0] imm;
    } desc_t;

endpackage

// File: rtl/instr_encoder_pack.sv
// Combinational packer: instruction descriptor -> 32-bit MIPS word plus legality.
module instr_pack
    import instr_encoder_pkg::*;
(
    input  desc_t       desc_i,
    output logic        legal_o,
    output logic [31:0] word_o
);

    always_comb begin
        legal_o = 1'b1;
        word_o  = '0;
        case (desc_i.kind)
            K_ADDU:    word_o = {OP_RTYPE, desc_i.rs, desc_i.rt, desc_i.rd, 5'b0, FN_ADDU};
            K_SUBU:    word_o = {OP_RTYPE, desc_i.rs, desc_i.rt, desc_i.rd, 5'b0, FN_SUBU};
            K_ORI:     word_o = {OP_ORI, desc_i.rs, desc_i.rt, desc_i.imm[15:0]};
            K_LW:      word_o = {OP_LW,  desc_i.rs, desc_i.rt, desc_i.imm[15:0]};
            K_SW:      word_o = {OP_SW,  desc_i.rs, desc_i.rt, desc_i.imm[15:0]};
            K_BEQ:     word_o = {OP_BEQ, desc_i.rs, desc_i.rt, desc_i.imm[15:0]};
            K_JAL:     word_o = {OP_JAL, desc_i.imm};
            K_ILLEGAL: legal_o = 1'b0;
        endcase
    end

endmodule

// File: rtl/instr_encoder.sv
// Sequential instruction encoder: accepts descriptors, packs them and writes
// them to instruction memory at sequential word addresses through one output stage.
module instr_encoder
    import instr_encoder_pkg::*;
#(
    parameter int unsigned ADDR_W = 8,
    parameter int unsigned DEPTH  = 256
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              start,
    input  logic              finish,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [2:0]        in_kind,
    input  logic [4:0]        in_rs,
    input  logic [4:0]        in_rt,
    input  logic [4:0]        in_rd,
    input  logic [25:0]       in_imm,
    output logic              im_we,
    input  logic              im_ready,
    output logic [ADDR_W-1:0] im_addr,
    output logic [31:0]       im_wdata,
    output logic [ADDR_W:0]   word_count,
    output logic              busy,
    output logic              done,
    output logic              err
);

    localparam int unsigned CNT_W = ADDR_W + 1;

    state_e              state_q, state_d;
    logic                we_q, we_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [31:0]         wdata_q, wdata_d;
    logic [CNT_W-1:0]    count_q, count_d;
    logic                err_q, err_d;
    logic                pend_q, pend_d;

    desc_t               desc;
    logic                legal_c;
    logic [31:0]         word_c;
    logic [CNT_W-1:0]    inflight_c;
    logic                accept_c;
    logic                commit_c;
    logic                full_c;

    assign desc = '{kind: kind_e'(in_kind), rs: in_rs, rt: in_rt, rd: in_rd, imm: in_imm};

    instr_pack u_pack (
        .desc_i  (desc),
        .legal_o (legal_c),
        .word_o  (word_c)
    );

    // Committed words plus the one held in the output register; also the next write address.
    assign inflight_c = count_q + CNT_W'(we_q);
    assign full_c     = (count_q == CNT_W'(DEPTH));
    assign commit_c   = we_q && im_ready;
    assign in_ready   = (state_q == ST_LOAD) && !start && !pend_q
                        && (inflight_c < CNT_W'(DEPTH)) && (!we_q || im_ready);
    assign accept_c   = in_valid && in_ready;

    always_comb begin
        state_d = state_q;
        we_d    = we_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        count_d = count_q;
        err_d   = err_q;
        pend_d  = pend_q;
        if (start) begin
            state_d = ST_LOAD;
            we_d    = 1'b0;
            addr_d  = '0;
            count_d = '0;
            err_d   = 1'b0;
            pend_d  = 1'b0;
        end else begin
            if (commit_c) begin
                count_d = count_q + CNT_W'(1);
                we_d    = 1'b0;
            end
            // A commit and a new load in the same cycle keep the stage full with no bubble.
            if (accept_c && legal_c) begin
                we_d    = 1'b1;
                addr_d  = ADDR_W'(inflight_c);
                wdata_d = word_c;
            end
            if (state_q == ST_LOAD) begin
                if (finish) begin
                    pend_d = 1'b1;
                end
                if (accept_c && !legal_c) begin
                    err_d   = 1'b1;
                    state_d = ST_ERR;
                end else if (in_valid && full_c) begin
                    err_d   = 1'b1;
                    state_d = ST_ERR;
                end else if ((finish || pend_q) && !we_q && !accept_c) begin
                    state_d = ST_DONE;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= ST_IDLE;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            count_q <= '0;
            err_q   <= 1'b0;
            pend_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            count_q <= count_d;
            err_q   <= err_d;
            pend_q  <= pend_d;
        end
    end

    assign im_we      = we_q;
    assign im_addr    = addr_q;
    assign im_wdata   = wdata_q;
    assign word_count = count_q;
    assign busy       = (state_q == ST_LOAD);
    assign done       = (state_q == ST_DONE);
    assign err        = err_q;

endmodule
